// File: rtl/jump_branch_unit.sv
// Execute-stage control-transfer resolver: JAL/JALR/branches with registered results
// and a flush sequencer that kills wrong-path instructions after a taken redirect.
module jump_branch_unit #(
   parameter int XLEN         = 32,
   parameter int IALIGN       = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            in_valid,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] imm,
   input  logic [5:0]      aluSelect,
   output logic            out_valid,
   output logic            redirect,
   output logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] link_value,
   output logic            misaligned,
   output logic            flush
);

   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_JALR = 6'b000100;
   localparam logic [5:0] OP_BEQ  = 6'b001000;
   localparam logic [5:0] OP_BNE  = 6'b001001;
   localparam logic [5:0] OP_BLT  = 6'b001100;
   localparam logic [5:0] OP_BGE  = 6'b001101;
   localparam logic [5:0] OP_BLTU = 6'b001110;
   localparam logic [5:0] OP_BGEU = 6'b001111;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
   localparam logic [3:0]      FLUSH_LEN = 4'(FLUSH_CYCLES);
   localparam logic            HAS_FLUSH = (FLUSH_CYCLES > 0);

   logic [0:0]      state_reg;
   logic [3:0]      cnt_reg;
   logic            known;
   logic            taken;
   logic            target_bad;
   logic            accept;
   logic            start_flush;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] target;

   always_comb begin
      known = 1'b1;
      taken = 1'b0;
      unique case (aluSelect)
         OP_JAL, OP_JALR: taken = 1'b1;
         OP_BEQ:          taken = (rs1 == rs2);
         OP_BNE:          taken = (rs1 != rs2);
         OP_BLT:          taken = ($signed(rs1) <  $signed(rs2));
         OP_BGE:          taken = ($signed(rs1) >= $signed(rs2));
         OP_BLTU:         taken = (rs1 <  rs2);
         OP_BGEU:         taken = (rs1 >= rs2);
         default:         known = 1'b0;
      endcase

      seq_pc = pc + PC_STEP;
      // JALR drops bit 0 of the computed address before alignment is judged
      if (aluSelect == OP_JALR)
         target = (rs1 + imm) & ~XLEN'(1);
      else
         target = pc + imm;

      target_bad  = (IALIGN == 32) ? (|target[1:0]) : target[0];
      accept      = in_valid & ~stall & (state_reg == ST_IDLE) & known;
      start_flush = accept & taken & ~target_bad & HAS_FLUSH;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         redirect   <= 1'b0;
         misaligned <= 1'b0;
         next_pc    <= '0;
         link_value <= '0;
         state_reg  <= ST_IDLE;
         cnt_reg    <= 4'd0;
      end else if (!stall) begin
         if (accept) begin
            out_valid  <= 1'b1;
            redirect   <= taken & ~target_bad;
            misaligned <= taken & target_bad;
            next_pc    <= taken ? target : seq_pc;
            link_value <= seq_pc;
         end else begin
            out_valid  <= 1'b0;
            redirect   <= 1'b0;
            misaligned <= 1'b0;
         end

         unique case (state_reg)
            ST_IDLE: begin
               if (start_flush) begin
                  state_reg <= ST_FLUSH;
                  cnt_reg   <= FLUSH_LEN;
               end
            end
            default: begin
               // last flush cycle: leave so the next edge can accept again
               cnt_reg <= cnt_reg - 4'd1;
               if (cnt_reg <= 4'd1)
                  state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign flush = (state_reg == ST_FLUSH);

endmodule

// File: tb/tb_jump_branch_unit.sv
// Scoreboard bench for jump_branch_unit: expected results are queued when an op is
// driven and compared once the registered result appears.
module tb_jump_branch_unit;

   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_JALR = 6'b000100;
   localparam logic [5:0] OP_BEQ  = 6'b001000;
   localparam logic [5:0] OP_BNE  = 6'b001001;
   localparam logic [5:0] OP_BLT  = 6'b001100;
   localparam logic [5:0] OP_BGE  = 6'b001101;
   localparam logic [5:0] OP_BLTU = 6'b001110;
   localparam logic [5:0] OP_BGEU = 6'b001111;

   typedef struct packed {
      logic [31:0] npc;
      logic [31:0] link;
      logic        redir;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, stall, in_valid;
   logic [31:0] pc, rs1, rs2, imm;
   logic [5:0]  alu_sel;
   logic        out_valid, redirect, misaligned, flush;
   logic [31:0] next_pc, link_value;
   logic        out_valid0, redirect0, misaligned0, flush0;
   logic [31:0] next_pc0, link_value0;

   exp_t exp_q[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   jump_branch_unit #(.XLEN(32), .IALIGN(32), .FLUSH_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid),
      .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm), .aluSelect(alu_sel),
      .out_valid(out_valid), .redirect(redirect), .next_pc(next_pc),
      .link_value(link_value), .misaligned(misaligned), .flush(flush)
   );

   jump_branch_unit #(.XLEN(32), .IALIGN(32), .FLUSH_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid),
      .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm), .aluSelect(alu_sel),
      .out_valid(out_valid0), .redirect(redirect0), .next_pc(next_pc0),
      .link_value(link_value0), .misaligned(misaligned0), .flush(flush0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] s, input logic [31:0] p, a, b, i);
      in_valid = 1'b1; alu_sel = s; pc = p; rs1 = a; rs2 = b; imm = i;
   endtask

   task automatic push(input logic [31:0] npc, link, input logic rd, mi);
      exp_t x;
      x.npc = npc; x.link = link; x.redir = rd; x.mis = mi;
      exp_q.push_back(x);
   endtask

   // Reference behaviour written from the instruction semantics
   function automatic exp_t model(input logic [5:0] s, input logic [31:0] p, a, b, i);
      exp_t x;
      logic tk;
      logic [31:0] tg;
      case (s)
         OP_BEQ:  tk = (a == b);
         OP_BNE:  tk = (a != b);
         OP_BLT:  tk = ($signed(a) < $signed(b));
         OP_BGE:  tk = !($signed(a) < $signed(b));
         OP_BLTU: tk = (a < b);
         OP_BGEU: tk = !(a < b);
         default: tk = 1'b1;
      endcase
      tg = (s == OP_JALR) ? {a[31:1] + i[31:1] + 31'(a[0] & i[0]), 1'b0} : p + i;
      x.mis   = tk && (tg[1:0] != 2'b00);
      x.redir = tk && !x.mis;
      x.npc   = tk ? tg : p + 32'd4;
      x.link  = p + 32'd4;
      return x;
   endfunction

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; in_valid = 1'b0;
      alu_sel = '0; pc = '0; rs1 = '0; rs2 = '0; imm = '0;
      tick(); tick();
      reset = 1'b0;
      n_vec++;
      if ({out_valid, redirect, misaligned, flush, next_pc, link_value} !== 68'd0) begin
         n_err++;
         $display("FAIL reset: got ov=%b rd=%b mis=%b fl=%b npc=%h link=%h, want all 0",
                  out_valid, redirect, misaligned, flush, next_pc, link_value);
      end
      n_vec++;
      if ({out_valid0, flush0} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_fc0: got ov=%b fl=%b, want 0 0", out_valid0, flush0);
      end
   endtask

   task automatic test_jal_flush();
      drive(OP_JAL, 32'h100, 32'h0, 32'h0, 32'd100);
      push(32'h164, 32'h104, 1'b1, 1'b0);
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ({out_valid, redirect, misaligned, next_pc, link_value, flush} !== {1'b1, e.redir, e.mis, e.npc, e.link, 1'b1}) begin
         n_err++;
         $display("FAIL jal: got ov=%b rd=%b mis=%b npc=%h link=%h fl=%b, want 1 %b %b %h %h 1",
                  out_valid, redirect, misaligned, next_pc, link_value, flush, e.redir, e.mis, e.npc, e.link);
      end
      drive(OP_BEQ, 32'h500, 32'h7, 32'h7, 32'h40);
      for (int k = 0; k < 2; k++) begin
         tick();
         n_vec++;
         if ({out_valid, flush} !== {1'b0, (k == 0)}) begin
            n_err++;
            $display("FAIL jal_drop%0d: got ov=%b fl=%b, want ov=0 fl=%b", k, out_valid, flush, (k == 0));
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_jalr();
      drive(OP_JALR, 32'h200, 32'd200, 32'h0, 32'd13);
      push(32'd212, 32'h204, 1'b1, 1'b0);
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ({out_valid, redirect, misaligned, next_pc, link_value, flush} !== {1'b1, e.redir, e.mis, e.npc, e.link, 1'b1}) begin
         n_err++;
         $display("FAIL jalr: got ov=%b rd=%b mis=%b npc=%h link=%h fl=%b, want 1 %b %b %h %h 1",
                  out_valid, redirect, misaligned, next_pc, link_value, flush, e.redir, e.mis, e.npc, e.link);
      end
      in_valid = 1'b0;
      tick(); tick();
      drive(OP_JALR, 32'h300, 32'd200, 32'h0, 32'd2);
      push(32'd202, 32'h304, 1'b0, 1'b1);
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ({out_valid, redirect, misaligned, next_pc, link_value, flush} !== {1'b1, e.redir, e.mis, e.npc, e.link, 1'b0}) begin
         n_err++;
         $display("FAIL jalr_misalign: got ov=%b rd=%b mis=%b npc=%h link=%h fl=%b, want 1 %b %b %h %h 0",
                  out_valid, redirect, misaligned, next_pc, link_value, flush, e.redir, e.mis, e.npc, e.link);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_branches();
      drive(OP_BLT, 32'h80, 32'hFFFF_FFFF, 32'h1, 32'h20);
      push(32'hA0, 32'h84, 1'b1, 1'b0);
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ({out_valid, redirect, next_pc, link_value, flush} !== {1'b1, e.redir, e.npc, e.link, 1'b1}) begin
         n_err++;
         $display("FAIL blt: got ov=%b rd=%b npc=%h link=%h fl=%b, want 1 %b %h %h 1",
                  out_valid, redirect, next_pc, link_value, flush, e.redir, e.npc, e.link);
      end
      in_valid = 1'b0;
      tick(); tick();
      // BLTU (not taken), then BEQ and BNE back-to-back (neither taken)
      drive(OP_BLTU, 32'h40, 32'hFFFF_FFFF, 32'h1, 32'h20);
      push(32'h44, 32'h44, 1'b0, 1'b0);
      push(32'h14, 32'h14, 1'b0, 1'b0);
      push(32'h18, 32'h18, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         e = exp_q.pop_front();
         n_vec++;
         if ({out_valid, redirect, next_pc, link_value, flush} !== {1'b1, e.redir, e.npc, e.link, 1'b0}) begin
            n_err++;
            $display("FAIL branch_b2b%0d: got ov=%b rd=%b npc=%h link=%h fl=%b, want 1 %b %h %h 0",
                     k, out_valid, redirect, next_pc, link_value, flush, e.redir, e.npc, e.link);
         end
         if (k == 0) drive(OP_BEQ, 32'h10, 32'h1, 32'h2, 32'h100);
         else if (k == 1) drive(OP_BNE, 32'h14, 32'h5, 32'h5, 32'h100);
         else in_valid = 1'b0;
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL branch_idle: got ov=%b, want 0", out_valid);
      end
   endtask

   task automatic test_wrap();
      drive(OP_JAL, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'd8);
      push(32'h4, 32'h0, 1'b1, 1'b0);
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ({out_valid, redirect, next_pc, link_value} !== {1'b1, e.redir, e.npc, e.link}) begin
         n_err++;
         $display("FAIL wrap: got ov=%b rd=%b npc=%h link=%h, want 1 %b %h %h",
                  out_valid, redirect, next_pc, link_value, e.redir, e.npc, e.link);
      end
      in_valid = 1'b0;
      tick(); tick();
   endtask

   task automatic test_stall();
      drive(OP_JAL, 32'h1000, 32'h0, 32'h0, 32'h40);
      push(32'h1040, 32'h1004, 1'b1, 1'b0);
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ({out_valid, redirect, next_pc, flush} !== {1'b1, e.redir, e.npc, 1'b1}) begin
         n_err++;
         $display("FAIL stall_jal: got ov=%b rd=%b npc=%h fl=%b, want 1 %b %h 1",
                  out_valid, redirect, next_pc, flush, e.redir, e.npc);
      end
      in_valid = 1'b0;
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++;
         if ({out_valid, redirect, flush} !== 3'b111) begin
            n_err++;
            $display("FAIL stall_hold%0d: got ov=%b rd=%b fl=%b, want 1 1 1", k, out_valid, redirect, flush);
         end
      end
      stall = 1'b0;
      tick();
      n_vec++;
      if ({out_valid, redirect, flush} !== 3'b001) begin
         n_err++;
         $display("FAIL stall_release: got ov=%b rd=%b fl=%b, want 0 0 1", out_valid, redirect, flush);
      end
      tick();
      n_vec++;
      if (flush !== 1'b0) begin
         n_err++;
         $display("FAIL stall_end: got fl=%b, want 0", flush);
      end
   endtask

   task automatic test_reset_mid_flush();
      drive(OP_JAL, 32'h2000, 32'h0, 32'h0, 32'h10);
      tick();
      n_vec++;
      if (flush !== 1'b1) begin
         n_err++;
         $display("FAIL rmf_start: got fl=%b, want 1", flush);
      end
      reset = 1'b1; stall = 1'b1;
      tick();
      reset = 1'b0; stall = 1'b0;
      n_vec++;
      if ({out_valid, redirect, misaligned, flush, next_pc, link_value} !== 68'd0) begin
         n_err++;
         $display("FAIL rmf_reset: got ov=%b rd=%b mis=%b fl=%b npc=%h link=%h, want all 0",
                  out_valid, redirect, misaligned, flush, next_pc, link_value);
      end
      drive(OP_JAL, 32'h3000, 32'h0, 32'h0, 32'h8);
      push(32'h3008, 32'h3004, 1'b1, 1'b0);
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ({out_valid, redirect, next_pc, link_value, flush} !== {1'b1, e.redir, e.npc, e.link, 1'b1}) begin
         n_err++;
         $display("FAIL rmf_jal: got ov=%b rd=%b npc=%h link=%h fl=%b, want 1 %b %h %h 1",
                  out_valid, redirect, next_pc, link_value, flush, e.redir, e.npc, e.link);
      end
      n_vec++;
      if ({out_valid0, redirect0, flush0, next_pc0} !== {1'b1, 1'b1, 1'b0, 32'h3008}) begin
         n_err++;
         $display("FAIL fc0_jal: got ov=%b rd=%b fl=%b npc=%h, want 1 1 0 00003008",
                  out_valid0, redirect0, flush0, next_pc0);
      end
      in_valid = 1'b0;
      tick(); tick();
   endtask

   task automatic test_unlisted();
      drive(6'b000000, 32'h7000, 32'h1, 32'h1, 32'h4);
      tick();
      n_vec++;
      if ({out_valid, flush, next_pc} !== {1'b0, 1'b0, 32'h3008}) begin
         n_err++;
         $display("FAIL unlisted: got ov=%b fl=%b npc=%h, want 0 0 00003008", out_valid, flush, next_pc);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_random();
      logic [5:0]  s;
      logic [31:0] a, b, i, p;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 7))
            0: s = OP_JAL;  1: s = OP_JALR; 2: s = OP_BEQ;  3: s = OP_BNE;
            4: s = OP_BLT;  5: s = OP_BGE;  6: s = OP_BLTU; default: s = OP_BGEU;
         endcase
         p = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         a = $urandom();
         b = ($urandom_range(0, 3) == 0) ? a : $urandom();
         i = ($urandom_range(0, 3) == 0) ? $urandom() : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         drive(s, p, a, b, i);
         exp_q.push_back(model(s, p, a, b, i));
         tick();
         e = exp_q.pop_front();
         n_vec++;
         if ({out_valid, redirect, misaligned, next_pc, link_value, flush} !== {1'b1, e.redir, e.mis, e.npc, e.link, e.redir}) begin
            n_err++;
            $display("FAIL rand%0d op=%b: got ov=%b rd=%b mis=%b npc=%h link=%h fl=%b, want 1 %b %b %h %h %b",
                     n, s, out_valid, redirect, misaligned, next_pc, link_value, flush,
                     e.redir, e.mis, e.npc, e.link, e.redir);
         end
         in_valid = 1'b0;
         if (e.redir) begin
            tick(); tick();
         end
      end
   endtask

   initial begin
      test_reset();
      test_jal_flush();
      test_jalr();
      test_branches();
      test_wrap();
      test_stall();
      test_reset_mid_flush();
      test_unlisted();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/jump_branch_unit.md
# jump_branch_unit

Registered, parametrised control-transfer resolution stage for the execute cycle: resolves JAL, JALR and all six conditional branches, produces the next PC, the link value and a misalignment flag, and runs a flush sequencer that kills wrong-path instructions after every taken redirect. It sits after operand fetch in the execute stage and drives the fetch redirect and pipeline-flush lines.

## Interface
- XLEN, 32: datapath width for pc, operands, immediate and results.
- IALIGN, 32: instruction alignment in bits; 32 means target[1:0] must be 0, 16 means only target[0] must be 0.
- FLUSH_CYCLES, 2: number of cycles flush stays high after a redirect; legal range 0–15.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; dominates stall.
- stall  in  1  freezes every register, including the flush counter and out_valid.
- in_valid  in  1  operand bundle valid this cycle.
- pc  in  XLEN  PC of the instruction.
- rs1, rs2  in  XLEN  register operands.
- imm  in  XLEN  sign-extended immediate.
- aluSelect  in  6  operation code.
- out_valid  out  1  result registers hold a newly resolved op (one-cycle pulse).
- redirect  out  1  fetch must load next_pc.
- next_pc  out  XLEN  resolved next PC.
- link_value  out  XLEN  pc + 4 (rd write data for JAL/JALR).
- misaligned  out  1  taken target violates IALIGN.
- flush  out  1  kill younger in-flight instructions.

## Operation
- Codes: JAL 6'b000011, JALR 6'b000100, BEQ 6'b001000, BNE 6'b001001, BLT 6'b001100, BGE 6'b001101, BLTU 6'b001110, BGEU 6'b001111.
- Targets: JAL and branches use pc + imm. JALR uses (rs1 + imm) with bit 0 cleared.
- All adds are modulo 2^XLEN, so wrap-around is silent.
- Taken conditions:
  - JAL and JALR are always taken.
  - BLT and BGE compare two's-complement signed; BLTU and BGEU compare unsigned.
- next_pc = taken ? target : pc + 4.
- link_value = pc + 4 for every accepted op.
- misaligned = taken & target misaligned per IALIGN. When misaligned is set, redirect = 0 and no flush is started. next_pc still carries the target.
- redirect = taken & ~misaligned.
- Accept: a cycle is accepted when in_valid & ~stall & ~reset, state is IDLE, and aluSelect is one of the listed codes.
  - Unlisted codes are ignored: out_valid stays 0 and the data outputs hold.
- FSM:
  - IDLE → FLUSH when an accepted op redirects and FLUSH_CYCLES > 0; counter loads FLUSH_CYCLES.
  - In FLUSH, flush = 1, in_valid is dropped (no accept, no output), and the counter decrements on each non-stalled cycle.
  - FLUSH → IDLE on the cycle the counter reaches 0.
  - With FLUSH_CYCLES = 0, the FSM never leaves IDLE and flush is constant 0.
- Reset values: out_valid, redirect, misaligned and flush are 0; next_pc and link_value are 0; state is IDLE and the counter is 0.
- Reset mid-flush: flush is 0 from the cycle after the reset edge, and the next instruction is accepted normally.

## Timing
- Latency 1: an op accepted at edge N shows out_valid, redirect, next_pc, link_value and misaligned during cycle N..N+1.
- redirect is high exactly while out_valid is high for that op.
- flush is high for FLUSH_CYCLES non-stalled cycles, starting the same cycle redirect is high.
- Inputs presented during those cycles are dropped.
- out_valid and redirect drop after one non-stalled cycle unless a new op is accepted.
- Back-to-back non-redirecting ops are accepted every cycle.
- stall held high freezes all outputs and the counter; a pulse is extended for the full stall duration.
- reset and stall in the same cycle: reset wins.

## Test plan
- JAL, pc=0x100, imm=100 → next_pc=0x164, link_value=0x104, redirect=1, flush high 2 cycles; a BEQ presented in those cycles produces no out_valid.
- JALR, rs1=200, imm=13 → next_pc=212, redirect=1. JALR, rs1=200, imm=2 (IALIGN=32) → next_pc=202, misaligned=1, redirect=0, flush=0.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken, redirect=1. BLTU with the same operands, pc=0x40 → next_pc=0x44, redirect=0, no flush. BEQ followed by BNE back-to-back, not taken → two consecutive out_valid pulses.
- Wrap-around: JAL pc=0xFFFFFFFC, imm=8 → next_pc=0x4, link_value=0x0.
- Stall 3 cycles during flush → flush stays high 2 + 3 cycles, and out_valid/redirect hold through the stall.
- Reset asserted in the first flush cycle → the following cycle all outputs are 0 and a new JAL is accepted; with FLUSH_CYCLES=0, a taken JAL gives redirect=1 and flush=0.
